// File: rtl/nn_stream_loader.sv
// Avalon-MM read master: fetches len_words words of one selectable region from SDRAM
// and streams them out through a credit-limited FIFO with valid/ready/last.
module nn_stream_loader #(
  parameter int                DATA_W        = 32,
  parameter int                ADDR_W        = 25,
  parameter int                LBITS         = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = '0,
  parameter logic [ADDR_W-1:0] REGION_STRIDE = 'h10000,
  parameter int                LEN_W         = 16,
  parameter int                FIFO_DEPTH    = 16,
  parameter int                MAX_PEND      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              get_data,
  input  logic [LBITS-1:0]  which_data,
  input  logic [LEN_W-1:0]  len_words,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]     DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]     MAXP_C   = CW'(MAX_PEND);
  localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(DATA_W / 8);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  issue_q, issue_d;
  logic [LEN_W-1:0]  pop_left_q, pop_left_d;
  logic [CW-1:0]     pend_q, pend_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic              rd_q, rd_d;
  logic [CW:0]       occ;
  logic [ADDR_W-1:0] start_addr;
  logic              accept, push, pop;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];

  always_comb begin
    accept     = rd_q & ~avm_waitrequest;
    push       = avm_readdatavalid;
    pop        = (cnt_q != '0) & out_ready;
    start_addr = BASE_ADDR + ADDR_W'(which_data) * REGION_STRIDE;

    state_d    = state_q;
    addr_d     = addr_q;
    issue_d    = issue_q;
    pend_d     = pend_q + CW'(accept) - CW'(push);
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    wptr_d     = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d     = pop ? rptr_q + PW'(1) : rptr_q;
    pop_left_d = pop ? pop_left_q - LEN_W'(1) : pop_left_q;

    case (state_q)
      S_IDLE: begin
        if (get_data) begin
          addr_d = start_addr;
          if (len_words != '0) begin
            issue_d    = len_words;
            pop_left_d = len_words;
            state_d    = S_READ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_READ: begin
        if (accept) begin
          addr_d  = addr_q + ADDR_INC;
          issue_d = issue_q - LEN_W'(1);
          if (issue_q == LEN_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && pop_left_q == LEN_W'(1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Credit check on post-edge counts: in-flight reads plus stored words never exceed
    // the FIFO, and the term cannot rise while a stalled read waits, so avm_read holds.
    occ  = {1'b0, pend_d} + {1'b0, cnt_d};
    rd_d = (issue_d != '0) && (pend_d < MAXP_C) && (occ < {1'b0, DEPTH_C});
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      issue_q    <= '0;
      pop_left_q <= '0;
      pend_q     <= '0;
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      rd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      issue_q    <= issue_d;
      pop_left_q <= pop_left_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      rd_q       <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= avm_readdata;
  end

  assign avm_address = addr_q;
  assign avm_read    = rd_q;
  assign busy        = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done        = (state_q == S_DONE);
  assign out_data    = mem[rptr_q];
  assign out_valid   = (cnt_q != '0);
  assign out_last    = out_valid && (pop_left_q == LEN_W'(1));

endmodule

// File: tb/tb_nn_stream_loader.sv
// Bench for nn_stream_loader: in-order SDRAM slave with latency and stalls, plus a
// transaction-level model of the expected read addresses and output stream.
module tb_nn_stream_loader;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned MAXP  = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        get_data = 1'b0;
  logic [1:0]  which_data = '0;
  logic [15:0] len_words = '0;
  logic        busy, done;
  logic [24:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;

  nn_stream_loader #(
    .DATA_W(32), .ADDR_W(25), .LBITS(2), .BASE_ADDR(25'h0), .REGION_STRIDE(25'h10000),
    .LEN_W(16), .FIFO_DEPTH(16), .MAX_PEND(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .get_data(get_data), .which_data(which_data),
    .len_words(len_words), .busy(busy), .done(done), .avm_address(avm_address),
    .avm_read(avm_read), .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct { int unsigned due; logic [31:0] data; } rsp_t;

  int unsigned n_chk = 0, n_fail = 0;
  int unsigned cyc = 0, last_due = 0;
  int          phase = 0;  // 0 idle, 1 busy, 2 done cycle
  int unsigned tlen = 0, n_acc = 0, n_ret = 0, n_pop = 0;
  logic [24:0] tbase = '0, prev_addr = '0;
  bit          prev_stall = 0, just_reset = 1;
  rsp_t        rq[$];
  logic [24:0] addr_log[$];
  logic [31:0] out_log[$];
  int unsigned done_cnt = 0, stall_cnt = 0, last_pos = 0;
  bit          rst_req = 1, start_pend = 0, ready_rand = 0, ready_val = 0, lat_rand = 0;
  int          wait_mode = 0;
  logic [1:0]  req_which = '0;
  logic [15:0] req_len = '0;

  function automatic logic [31:0] memf(input logic [24:0] a);
    return 32'(a >> 2) + 32'd1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock cycle: check outputs, drive inputs for the next edge, advance the model.
  task automatic step();
    bit acc, ret, pop, exp_rd;
    int unsigned occ, due;
    @(negedge clk);
    if (just_reset) chk("reset_address", avm_address, 0);
    exp_rd = (phase == 1) && (n_acc < tlen) && (n_acc - n_ret < MAXP) && (n_acc - n_pop < DEPTH);
    chk("avm_read", avm_read, exp_rd);
    if (avm_read && exp_rd) chk("avm_address", avm_address, tbase + 25'(4 * n_acc));
    if (prev_stall) begin
      chk("hold_read", avm_read, 1);
      chk("hold_address", avm_address, prev_addr);
    end
    occ = n_ret - n_pop;
    chk("out_valid", out_valid, occ != 0);
    if (out_valid && occ != 0) begin
      chk("out_data", out_data, memf(tbase + 25'(4 * n_pop)));
      chk("out_last", out_last, n_pop + 1 == tlen);
    end
    chk("busy", busy, phase == 1);
    chk("done", done, phase == 2);
    if (done) done_cnt++;

    reset_n  = !rst_req;
    get_data = 1'b0;
    if (start_pend) begin
      get_data   = 1'b1;
      which_data = req_which;
      len_words  = req_len;
      start_pend = 0;
    end
    out_ready = ready_rand ? ($urandom_range(0, 1) == 1) : ready_val;
    case (wait_mode)
      1:       avm_waitrequest = avm_read && ($urandom_range(0, 2) == 0);
      2:       avm_waitrequest = avm_read && (n_acc == 1) && (stall_cnt < 5);
      default: avm_waitrequest = 1'b0;
    endcase
    avm_readdatavalid = 1'b0;
    avm_readdata      = $urandom;
    if (rst_req) rq.delete();
    else if (rq.size() != 0 && rq[0].due <= cyc) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = rq[0].data;
      void'(rq.pop_front());
    end

    if (rst_req) begin
      phase = 0; tlen = 0; n_acc = 0; n_ret = 0; n_pop = 0;
      prev_stall = 0; just_reset = 1;
    end else begin
      just_reset = 0;
      acc = avm_read && !avm_waitrequest;
      ret = avm_readdatavalid;
      pop = out_valid && out_ready;
      if (avm_read && avm_waitrequest) stall_cnt++;
      prev_stall = avm_read && avm_waitrequest;
      prev_addr  = avm_address;
      if (acc) begin
        addr_log.push_back(avm_address);
        due = cyc + (lat_rand ? $urandom_range(1, 4) : 2);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        rq.push_back('{due: due, data: memf(avm_address)});
        n_acc++;
      end
      if (ret) n_ret++;
      if (pop) begin
        out_log.push_back(out_data);
        if (out_last) last_pos = n_pop;
        n_pop++;
      end
      case (phase)
        2: phase = 0;
        0: if (get_data) begin
             tbase = 25'(32'(which_data) * 32'h10000);
             tlen  = len_words;
             n_acc = 0; n_ret = 0; n_pop = 0; stall_cnt = 0;
             phase = (len_words != 0) ? 1 : 2;
           end
        default: if (pop && n_pop == tlen) phase = 2;
      endcase
    end
    cyc++;
  endtask

  task automatic start(input logic [1:0] w, input logic [15:0] l);
    req_which  = w;
    req_len    = l;
    start_pend = 1;
    step();
  endtask

  task automatic wait_done(input int unsigned bound, input string nm);
    int unsigned d0 = done_cnt;
    int unsigned i = 0;
    while (done_cnt == d0 && i < bound) begin
      step();
      i++;
    end
    chk(nm, done_cnt - d0, 1);
    step();
  endtask

  initial begin
    int unsigned a0, o0, d0;
    logic [24:0] t1a [4];
    t1a = '{25'h0, 25'h4, 25'h8, 25'hC};

    repeat (3) step();
    rst_req = 0;
    repeat (2) step();

    // 1: region 0, four words, no stalls, latency 2
    ready_val = 1;
    a0 = addr_log.size(); o0 = out_log.size();
    start(0, 4);
    wait_done(100, "t1_done");
    chk("t1_nreads", addr_log.size() - a0, 4);
    chk("t1_nwords", out_log.size() - o0, 4);
    if (addr_log.size() >= a0 + 4 && out_log.size() >= o0 + 4)
      for (int i = 0; i < 4; i++) begin
        chk("t1_addr", addr_log[a0 + i], t1a[i]);
        chk("t1_data", out_log[o0 + i], 32'(i + 1));
      end
    chk("t1_last_pos", last_pos, 3);

    // 2: region 2 base address
    a0 = addr_log.size(); o0 = out_log.size();
    start(2, 3);
    wait_done(100, "t2_done");
    chk("t2_first_addr", (addr_log.size() > a0) ? addr_log[a0] : 25'h1FFFFFF, 25'h20000);
    chk("t2_first_word", (out_log.size() > o0) ? out_log[o0] : 32'h0, 32'h8001);

    // 3: consumer stalled, credit limit stops issue at FIFO depth
    ready_val = 0;
    a0 = addr_log.size(); o0 = out_log.size();
    start(1, 40);
    repeat (60) step();
    chk("t3_reads_at_stall", addr_log.size() - a0, 16);
    chk("t3_read_low", avm_read, 0);
    ready_val = 1;
    wait_done(500, "t3_done");
    chk("t3_nwords", out_log.size() - o0, 40);
    chk("t3_final_word", (out_log.size() >= o0 + 40) ? out_log[o0 + 39] : 32'h0, 32'h4028);

    // 4: five-cycle waitrequest on the second read
    wait_mode = 2; lat_rand = 1;
    o0 = out_log.size();
    start(3, 6);
    wait_done(200, "t4_done");
    chk("t4_stall_cycles", stall_cnt, 5);
    chk("t4_nwords", out_log.size() - o0, 6);
    chk("t4_second_word", (out_log.size() > o0 + 1) ? out_log[o0 + 1] : 32'h0, 32'hC002);
    wait_mode = 0;

    // 5: zero length, then a start request while busy
    d0 = done_cnt; a0 = addr_log.size();
    start(2, 0);
    step();
    chk("t5_done_next", done, 1);
    step();
    chk("t5_one_done", done_cnt - d0, 1);
    chk("t5_no_reads", addr_log.size() - a0, 0);
    ready_rand = 1;
    o0 = out_log.size();
    start(1, 8);
    repeat (4) step();
    start(2, 5);
    wait_done(500, "t5_done");
    chk("t5_nwords", out_log.size() - o0, 8);
    chk("t5_first_word", (out_log.size() > o0) ? out_log[o0] : 32'h0, 32'h4001);
    ready_rand = 0;

    // 6: reset in the middle of a stalled transfer
    ready_val = 0;
    start(1, 40);
    repeat (12) step();
    d0 = done_cnt;
    rst_req = 1;
    step();
    rst_req = 0;
    step();
    chk("t6_valid", out_valid, 0);
    chk("t6_read", avm_read, 0);
    chk("t6_busy", busy, 0);
    repeat (3) step();
    chk("t6_no_done", done_cnt - d0, 0);
    ready_val = 1;
    o0 = out_log.size();
    start(0, 4);
    wait_done(200, "t6_done");
    chk("t6_nwords", out_log.size() - o0, 4);
    chk("t6_first_word", (out_log.size() > o0) ? out_log[o0] : 32'h0, 32'h1);

    // Randomised transfers
    wait_mode = 1; ready_rand = 1; lat_rand = 1;
    for (int t = 0; t < 12; t++) begin
      start(2'($urandom_range(0, 3)), 16'($urandom_range(1, 40)));
      wait_done(3000, "rand_done");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
